id_exe_pipe: RTL

Parametrised ID/EXE pipeline register with a valid/ready handshake, flush, and an optional one-entry skid buffer. It sits between the decode stage and the execute stage. It carries the decoded operands, write-back control, instruction and instruction address. It lets execute back-pressure decode, and lets the branch/trap logic squash the in-flight instruction. Bubbles always present as a NOP with writes disabled.

---
 rtl/id_exe_pipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/id_exe_pipe.sv
// id_exe_pipe: ID/EXE pipeline register with valid/ready handshake and flush.
// Bubbles always present as NOP_INST with register writes disabled.
// Optional one-entry skid buffer: define ID_EXE_SKID_EN to build it. With it,
// ready_o is registered. Without it, ready_o = !valid_o | exe_ready_i.
module id_exe_pipe #(
  parameter int RDATA_WIDTH = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   id_valid_i,
  output logic                   ready_o,
  input  logic [RDATA_WIDTH-1:0] op1_i,
  input  logic [RDATA_WIDTH-1:0] op2_i,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic [DATA_WIDTH-1:0]  inst_i,
  input  logic [ADDR_WIDTH-1:0]  inst_addr_i,
  input  logic                   flush_i,
  input  logic                   exe_ready_i,
  output logic                   valid_o,
  output logic [RDATA_WIDTH-1:0] op1_o,
  output logic [RDATA_WIDTH-1:0] op2_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic [DATA_WIDTH-1:0]  inst_o,
  output logic [ADDR_WIDTH-1:0]  inst_addr_o
);

  // Payload packed as {op1, op2, reg_we, reg_waddr, inst, inst_addr}.
  localparam int PW = 2*RDATA_WIDTH + 1 + RADDR_WIDTH + DATA_WIDTH + ADDR_WIDTH;
  localparam logic [PW-1:0] BUBBLE =
    {{(2*RDATA_WIDTH + 1 + RADDR_WIDTH){1'b0}}, NOP_INST, {ADDR_WIDTH{1'b0}}};

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
`ifdef ID_EXE_SKID_EN
  localparam logic [1:0] ST_SKID  = 2'd2;
`endif

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [PW-1:0] r_main;
  logic [PW-1:0] w_main_next;
  logic [PW-1:0] w_in_pay;
  logic          w_valid;
  logic          w_in_fire;
  logic          w_out_fire;

`ifdef ID_EXE_SKID_EN
  logic [PW-1:0] r_skid;
  logic [PW-1:0] w_skid_next;
  logic          r_ready;
`endif

  assign w_in_pay   = {op1_i, op2_i, reg_we_i, reg_waddr_i, inst_i, inst_addr_i};
  assign w_valid    = (r_state != ST_EMPTY);
  assign valid_o    = w_valid;
  assign w_in_fire  = id_valid_i & ready_o;
  assign w_out_fire = w_valid & exe_ready_i;

`ifdef ID_EXE_SKID_EN
  // Registered ready breaks the combinational path from exe_ready_i.
  assign ready_o = r_ready;
`else
  assign ready_o = !w_valid | exe_ready_i;
`endif

  assign {op1_o, op2_o, reg_we_o, reg_waddr_o, inst_o, inst_addr_o} = r_main;

  // Next-state and payload selection; flush overrides every transition.
  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
`ifdef ID_EXE_SKID_EN
    w_skid_next  = r_skid;
`endif
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_next = ST_FULL;
          w_main_next  = w_in_pay;
        end
      end
      ST_FULL: begin
        if (w_in_fire && w_out_fire) begin
          w_main_next = w_in_pay;
`ifdef ID_EXE_SKID_EN
        end else if (w_in_fire) begin
          // Execute stalled: park the younger instruction in the skid slot.
          w_state_next = ST_SKID;
          w_skid_next  = w_in_pay;
`endif
        end else if (w_out_fire) begin
          w_state_next = ST_EMPTY;
          w_main_next  = BUBBLE;
        end
      end
`ifdef ID_EXE_SKID_EN
      ST_SKID: begin
        if (w_out_fire) begin
          w_state_next = ST_FULL;
          w_main_next  = r_skid;
          w_skid_next  = BUBBLE;
        end
      end
`endif
      default: begin
        w_state_next = ST_EMPTY;
        w_main_next  = BUBBLE;
      end
    endcase
    if (flush_i) begin
      w_state_next = ST_EMPTY;
      w_main_next  = BUBBLE;
`ifdef ID_EXE_SKID_EN
      w_skid_next  = BUBBLE;
`endif
    end
  end

  // State and payload registers with synchronous reset to the bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
      r_main  <= BUBBLE;
`ifdef ID_EXE_SKID_EN
      r_skid  <= BUBBLE;
      r_ready <= 1'b1;
`endif
    end else begin
      r_state <= w_state_next;
      r_main  <= w_main_next;
`ifdef ID_EXE_SKID_EN
      r_skid  <= w_skid_next;
      r_ready <= (w_state_next != ST_SKID);
`endif
    end
  end

endmodule
